// File: rtl/fp32_pkg.sv
// Shared FP32 field constants, canonical encodings and the operand class struct.
package fp32_pkg;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;

    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

    localparam logic [31:0] QNAN     = 32'h7FC0_0000;
    localparam logic [31:0] POS_ZERO = 32'h0000_0000;
    localparam logic [31:0] NEG_ZERO = 32'h8000_0000;
    localparam logic [31:0] POS_INF  = 32'h7F80_0000;
    localparam logic [31:0] NEG_INF  = 32'hFF80_0000;

    typedef struct packed {
        logic is_zero;
        logic is_inf;
        logic is_nan;
        logic is_sub;
    } fp32_class_t;

    // Subnormals and normals both count as nonzero finite.
    function automatic logic is_nonzero_finite(input fp32_class_t c);
        return c.is_sub | ~(c.is_zero | c.is_inf | c.is_nan);
    endfunction

    // Force the quiet bit while keeping sign and the low payload bits.
    function automatic logic [31:0] quiet_nan(input logic [31:0] x);
        return {x[31], EXP_MAX, 1'b1, x[MAN_W-2:0]};
    endfunction

endpackage

// File: rtl/fp32_classify.sv
// Combinational FP32 operand classifier: zero, infinity, NaN, subnormal.
module fp32_classify
    import fp32_pkg::*;
(
    input  logic [31:0]  x_i,
    output fp32_class_t  cls_o
);

    logic exp_zero;
    logic exp_max;
    logic man_zero;

    assign exp_zero = (x_i[30:23] == '0);
    assign exp_max  = (x_i[30:23] == EXP_MAX);
    assign man_zero = (x_i[22:0] == '0);

    assign cls_o.is_zero = exp_zero & man_zero;
    assign cls_o.is_inf  = exp_max & man_zero;
    assign cls_o.is_nan  = exp_max & ~man_zero;
    assign cls_o.is_sub  = exp_zero & ~man_zero;

endmodule

// File: rtl/special_add.sv
// FP32 add/sub special-case resolver with a single output register stage.
// Optional build macro: SPECIAL_ADD_NAN_PAYLOAD_EN (propagate quieted NaN payloads).
module special_add
    import fp32_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        symbol,
    output logic [31:0] out,
    output logic        check_special
);

    fp32_class_t a_cls;
    fp32_class_t b_cls;

    fp32_classify u_cls_a (.x_i(a), .cls_o(a_cls));
    fp32_classify u_cls_b (.x_i(b), .cls_o(b_cls));

    logic        sb;
    logic [31:0] nan_res;
    logic [31:0] out_d, out_q;
    logic        special_d, special_q;

    assign sb = b[31] ^ symbol;

`ifdef SPECIAL_ADD_NAN_PAYLOAD_EN
    // B's payload keeps B's own sign bit, not the effective sign.
    assign nan_res = a_cls.is_nan ? quiet_nan(a) : quiet_nan(b);
`else
    assign nan_res = QNAN;
`endif

    always_comb begin
        out_d     = POS_ZERO;
        special_d = 1'b1;
        if (a_cls.is_nan | b_cls.is_nan) begin
            out_d = nan_res;
        end else if (a_cls.is_inf & b_cls.is_inf) begin
            out_d = (a[31] == sb) ? a : QNAN;
        end else if (a_cls.is_inf) begin
            out_d = a;
        end else if (b_cls.is_inf) begin
            out_d = {sb, b[30:0]};
        end else if (a_cls.is_zero & b_cls.is_zero) begin
            out_d = (a[31] & sb) ? NEG_ZERO : POS_ZERO;
        end else if (a_cls.is_zero) begin
            out_d = {sb, b[30:0]};
        end else if (b_cls.is_zero) begin
            out_d = a;
        end else if ((a[30:0] == b[30:0]) && is_nonzero_finite(a_cls) &&
                     is_nonzero_finite(b_cls) && (a[31] != sb)) begin
            out_d = POS_ZERO;
        end else begin
            special_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q     <= POS_ZERO;
            special_q <= 1'b0;
        end else begin
            out_q     <= out_d;
            special_q <= special_d;
        end
    end

    assign out           = out_q;
    assign check_special = special_q;

endmodule

// File: tb/tb_special_add.sv
// Self-checking bench for special_add: directed IEEE cases plus biased random operands.
module tb_special_add;

    logic        clk;
    logic        rst;
    logic [31:0] a;
    logic [31:0] b;
    logic        symbol;
    logic [31:0] out_w;
    logic        chk_w;

    int n_tests;
    int n_fail;

    logic [32:0] exp_q[$];
    logic [32:0] last_exp;

    special_add dut (
        .clk           (clk),
        .rst           (rst),
        .a             (a),
        .b             (b),
        .symbol        (symbol),
        .out           (out_w),
        .check_special (chk_w)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h", tag, got, want);
        end
    endtask

    // Reference model: {check_special, out} from the IEEE rules on raw fields.
    function automatic logic [32:0] ref_model(input logic [31:0] ta, input logic [31:0] tb,
                                              input logic sym);
        int unsigned ea, eb, ma, mb;
        logic sa, sbe;
        bit a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        logic [31:0] qn;
        ea = ta[30:23]; ma = ta[22:0]; sa = ta[31];
        eb = tb[30:23]; mb = tb[22:0]; sbe = tb[31] ^ sym;
        a_nan  = (ea == 255) && (ma != 0);
        b_nan  = (eb == 255) && (mb != 0);
        a_inf  = (ea == 255) && (ma == 0);
        b_inf  = (eb == 255) && (mb == 0);
        a_zero = (ea == 0) && (ma == 0);
        b_zero = (eb == 0) && (mb == 0);
`ifdef SPECIAL_ADD_NAN_PAYLOAD_EN
        if (a_nan) qn = (ta & 32'h803F_FFFF) | 32'h7FC0_0000;
        else       qn = (tb & 32'h803F_FFFF) | 32'h7FC0_0000;
`else
        qn = 32'h7FC0_0000;
`endif
        if (a_nan || b_nan) return {1'b1, qn};
        if (a_inf && b_inf) return (sa == sbe) ? {1'b1, ta} : {1'b1, 32'h7FC0_0000};
        if (a_inf) return {1'b1, ta};
        if (b_inf) return {1'b1, sbe ? 32'hFF80_0000 : 32'h7F80_0000};
        if (a_zero && b_zero) return {1'b1, (sa && sbe) ? 32'h8000_0000 : 32'h0};
        if (a_zero) return {1'b1, sbe, tb[30:0]};
        if (b_zero) return {1'b1, ta};
        if (ea == eb && ma == mb && sa != sbe) return {1'b1, 32'h0};
        return 33'h0;
    endfunction

    // driver: inputs at negedge, outputs checked 1 time unit after the next posedge
    task automatic drive(input string tag, input logic r, input logic [31:0] ta,
                         input logic [31:0] tb, input logic ts);
        logic [32:0] e;
        @(negedge clk);
        rst = r; a = ta; b = tb; symbol = ts;
        exp_q.push_back(r ? 33'h0 : ref_model(ta, tb, ts));
        #1;
        // nothing may change before the capturing edge
        check_val({tag, ".hold_out"}, out_w, last_exp[31:0]);
        check_val({tag, ".hold_chk"}, {31'b0, chk_w}, {31'b0, last_exp[32]});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        last_exp = e;
        check_val({tag, ".out"}, out_w, e[31:0]);
        check_val({tag, ".chk"}, {31'b0, chk_w}, {31'b0, e[32]});
    endtask

    function automatic logic [31:0] rand_op(input int kind);
        logic s;
        s = 1'($urandom_range(0, 1));
        case (kind)
            0: return {s, 31'h0};
            1: return {s, 8'hFF, 23'h0};
            2: return {s, 8'hFF, 23'($urandom_range(1, 32'h7F_FFFF))};
            3: return {s, 8'h00, 23'($urandom_range(1, 32'h7F_FFFF))};
            default: return {s, 8'($urandom_range(1, 254)), 23'($urandom)};
        endcase
    endfunction

    initial begin
        logic [31:0] ra, rb;
        n_tests  = 0;
        n_fail   = 0;
        last_exp = 33'h0;
        rst = 1'b1; a = '0; b = '0; symbol = 1'b0;

        drive("reset0", 1'b1, 32'h7FC0_0001, 32'h0, 1'b0);
        drive("reset1", 1'b1, 32'h0, 32'h0, 1'b0);

        drive("zz_add",    1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0);
        drive("nz_sub_z",  1'b0, 32'h8000_0000, 32'h0000_0000, 1'b1);
        drive("nz_sub_nz", 1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0);
        drive("za_add",    1'b0, 32'h0000_0000, 32'hC06C_CCCD, 1'b0);
        drive("za_sub",    1'b0, 32'h0000_0000, 32'hC06C_CCCD, 1'b1);
        drive("zb_add",    1'b0, 32'hC06C_CCCD, 32'h0000_0000, 1'b0);
        drive("inf_opp",   1'b0, 32'h7F80_0000, 32'hFF80_0000, 1'b0);
        drive("inf_same",  1'b0, 32'h7F80_0000, 32'hFF80_0000, 1'b1);
        drive("fin_m_inf", 1'b0, 32'h406C_CCCD, 32'hFF80_0000, 1'b1);
        drive("fin_p_inf", 1'b0, 32'hC06C_CCCD, 32'h7F80_0000, 1'b0);
        drive("cancel",    1'b0, 32'h406C_CCCD, 32'h406C_CCCD, 1'b1);
        drive("finite",    1'b0, 32'h406C_CCCD, 32'h406C_CCCD, 1'b0);
        drive("nan_a",     1'b0, 32'hFF80_0001, 32'h406C_CCCD, 1'b0);
        drive("nan_ab",    1'b0, 32'hFF80_0001, 32'h7F80_0001, 1'b1);
        drive("nan_b",     1'b0, 32'h3F80_0000, 32'hFFA0_1234, 1'b1);
        drive("sub_cancel",1'b0, 32'h0000_0005, 32'h8000_0005, 1'b0);
        drive("sub_plain", 1'b0, 32'h0000_0005, 32'h0000_0006, 1'b1);

        // mid-stream reset with NaN inputs, then release
        drive("rst_mid",   1'b1, 32'h7FC0_0001, 32'hFFFF_FFFF, 1'b0);
        drive("rst_rel",   1'b0, 32'h7F80_0000, 32'h7F80_0000, 1'b0);

        for (int i = 0; i < 400; i++) begin
            ra = rand_op($urandom_range(0, 4));
            if ($urandom_range(0, 3) == 0)
                rb = {1'($urandom_range(0, 1)), ra[30:0]};
            else
                rb = rand_op($urandom_range(0, 4));
            drive($sformatf("rand%0d", i), ($urandom_range(0, 49) == 0), ra, rb,
                  1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
